// File: rtl/keypad_timer_entry_if.sv
// keypad_timer_entry_if: keypad, run control and timer-load bus of the oven timer entry controller
interface keypad_timer_entry_if #(parameter int KEYS = 10, parameter int DIGITS = 4);
    logic [KEYS-1:0] keypad;
    logic enablen;
    logic cancel;
    logic [3:0] D;
    logic loadn;
    logic pgt_1Hz;
    logic [4*DIGITS-1:0] entry;
    logic full;
    modport master(output keypad, enablen, cancel, input D, loadn, pgt_1Hz, entry, full);
    modport slave(input keypad, enablen, cancel, output D, loadn, pgt_1Hz, entry, full);
endinterface

// File: rtl/keypad_timer_entry.sv
// keypad_timer_entry: debounced priority keypad, BCD entry shift register, load strobe and run-gated tick divider
module keypad_timer_entry #(
    parameter int KEYS = 10,
    parameter int DIGITS = 4,
    parameter int DIV = 100,
    parameter int DEBOUNCE = 3
) (
    input logic clk100,
    input logic clearn,
    keypad_timer_entry_if.slave bus
);
    localparam int EW = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int DW = $clog2(DIV);
    localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, ACCEPT = 2'd2, HOLD = 2'd3;
    logic [KEYS-1:0] s1, ks;
    logic [3:0] enc, cand;
    logic zero;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [NW-1:0] count;
    logic [DW-1:0] div;
    logic en_q;
    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < KEYS; i++) if (ks[i]) enc = 4'(i);
    end
    assign zero = ~|ks;
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            s1 <= '0;
            ks <= '0;
            state <= IDLE;
            cnt <= '0;
            cand <= '0;
            bus.D <= '0;
            bus.loadn <= 1'b1;
        end else begin
            s1 <= bus.keypad;
            ks <= s1;
            bus.loadn <= 1'b1;
            case (state)
                IDLE: if (bus.enablen && !zero) begin
                    cand <= enc;
                    cnt <= CW'(1);
                    state <= SETTLE;
                end
                SETTLE: if (zero || !bus.enablen) state <= IDLE;
                else if (enc != cand) begin
                    cand <= enc;
                    cnt <= CW'(1);
                end else if (cnt == CW'(DEBOUNCE)) begin
                    state <= ACCEPT;
                    bus.loadn <= 1'b0;
                    bus.D <= cand;
                end else cnt <= cnt + 1'b1;
                ACCEPT: begin
                    state <= HOLD;
                    cnt <= '0;
                end
                default: if (!zero) cnt <= '0;
                else if (cnt == CW'(DEBOUNCE - 1)) state <= IDLE;
                else cnt <= cnt + 1'b1;
            endcase
        end
    end
    // cancel outranks a simultaneous accept; a full register still strobes but does not shift
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            bus.entry <= '0;
            count <= '0;
            bus.full <= 1'b0;
        end else if (bus.cancel) begin
            bus.entry <= '0;
            count <= '0;
            bus.full <= 1'b0;
        end else if (state == ACCEPT && count != NW'(DIGITS)) begin
            bus.entry <= EW'({bus.entry, cand});
            count <= count + 1'b1;
            bus.full <= count == NW'(DIGITS - 1);
        end
    end
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            en_q <= 1'b1;
            div <= '0;
            bus.pgt_1Hz <= 1'b0;
        end else begin
            en_q <= bus.enablen;
            div <= en_q || div == DW'(DIV - 1) ? '0 : div + 1'b1;
            bus.pgt_1Hz <= bus.enablen ? state == ACCEPT : !en_q && div == DW'(DIV - 1);
        end
    end
endmodule

// File: tb/tb_keypad_timer_entry.sv
// tb_keypad_timer_entry: scenario tasks plus randomized key sequences against a digit-queue entry model
module tb_keypad_timer_entry;
    logic clk100 = 1'b0;
    logic clearn = 1'b1;
    int vecs = 0;
    int errs = 0;
    int model[$];
    keypad_timer_entry_if #(.KEYS(10), .DIGITS(4)) bus();
    keypad_timer_entry #(.KEYS(10), .DIGITS(4), .DIV(100), .DEBOUNCE(3)) dut (
        .clk100(clk100),
        .clearn(clearn),
        .bus(bus)
    );
    always #5 clk100 = ~clk100;

    function automatic logic [15:0] model_entry();
        logic [15:0] v = '0;
        foreach (model[j]) v = {v[11:0], 4'(model[j])};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        model.delete();
    endtask

    task automatic press(input logic [9:0] mask, input int hold, input int gap, input bit cancel_acc,
                         output int np, output int lat, output logic [3:0] d, output logic pg);
        bit prev = 1'b0;
        np = 0;
        lat = -1;
        d = '0;
        pg = 1'b0;
        bus.keypad = mask;
        for (int i = 0; i < hold + gap; i++) begin
            tick();
            if (prev) begin
                d = bus.D;
                pg = bus.pgt_1Hz;
            end
            prev = !bus.loadn;
            if (!bus.loadn) begin
                np++;
                if (lat < 0) lat = i;
            end
            bus.cancel = cancel_acc && prev;
            if (i == hold - 1) bus.keypad = '0;
        end
        bus.cancel = 1'b0;
    endtask

    task automatic test_reset();
        #2 clearn = 1'b0;
        tick();
        tick();
        vecs++; if (bus.loadn !== 1'b1) begin errs++; $display("FAIL reset_loadn got %b exp 1", bus.loadn); end
        vecs++; if (bus.D !== 4'h0) begin errs++; $display("FAIL reset_D got %h exp 0", bus.D); end
        vecs++; if (bus.pgt_1Hz !== 1'b0) begin errs++; $display("FAIL reset_pgt got %b exp 0", bus.pgt_1Hz); end
        vecs++; if (bus.entry !== 16'h0) begin errs++; $display("FAIL reset_entry got %h exp 0", bus.entry); end
        vecs++; if (bus.full !== 1'b0) begin errs++; $display("FAIL reset_full got %b exp 0", bus.full); end
        clearn = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_settle();
        int np, lat, lows;
        logic [3:0] d;
        logic pg;
        lows = 0;
        bus.keypad = 10'h020;
        tick();
        tick();
        tick();
        clearn = 1'b0;
        #1;
        vecs++; if (bus.entry !== 16'h0 || bus.D !== 4'h0 || bus.loadn !== 1'b1) begin errs++; $display("FAIL midrst_outputs got entry=%h D=%h loadn=%b exp 0 0 1", bus.entry, bus.D, bus.loadn); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!bus.loadn) lows++;
        end
        vecs++; if (lows !== 0) begin errs++; $display("FAIL midrst_no_pulse got %0d exp 0", lows); end
        clearn = 1'b1;
        model.delete();
        press(10'h020, 6, 8, 1'b0, np, lat, d, pg);
        model.push_back(5);
        vecs++; if (lat !== 5) begin errs++; $display("FAIL midrst_latency got %0d exp 5", lat); end
        vecs++; if (np !== 1) begin errs++; $display("FAIL midrst_pulses got %0d exp 1", np); end
        vecs++; if (d !== 4'd5) begin errs++; $display("FAIL midrst_D got %h exp 5", d); end
        vecs++; if (bus.entry !== model_entry()) begin errs++; $display("FAIL midrst_entry got %h exp %h", bus.entry, model_entry()); end
    endtask

    task automatic test_priority();
        int np, lat;
        logic [3:0] d;
        logic pg;
        do_cancel();
        press(10'h204, 5, 3, 1'b0, np, lat, d, pg);
        vecs++; if (np !== 1) begin errs++; $display("FAIL prio_pulses got %0d exp 1", np); end
        vecs++; if (d !== 4'd9) begin errs++; $display("FAIL prio_D got %h exp 9", d); end
        vecs++; if (bus.entry !== 16'h0009) begin errs++; $display("FAIL prio_entry got %h exp 0009", bus.entry); end
        vecs++; if (pg !== 1'b1) begin errs++; $display("FAIL prio_post_load_pgt got %b exp 1", pg); end
        model.push_back(9);
        tick();
        tick();
    endtask

    task automatic test_bounce();
        int np, lat, lows;
        logic [3:0] d;
        logic pg;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            bus.keypad = (i % 2 == 0) ? 10'h008 : 10'h000;
            tick();
            if (!bus.loadn) lows++;
        end
        bus.keypad = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!bus.loadn) lows++;
        end
        vecs++; if (lows !== 0) begin errs++; $display("FAIL bounce_rejected got %0d pulses exp 0", lows); end
        bus.keypad = 10'h008;
        tick();
        tick();
        press(10'h010, 6, 8, 1'b0, np, lat, d, pg);
        vecs++; if (np !== 1) begin errs++; $display("FAIL bounce_change_pulses got %0d exp 1", np); end
        vecs++; if (d !== 4'd4) begin errs++; $display("FAIL bounce_change_D got %h exp 4", d); end
        if (model.size() < 4) model.push_back(4);
    endtask

    task automatic test_fill();
        int np, lat;
        logic [3:0] d;
        logic pg;
        do_cancel();
        for (int k = 1; k <= 5; k++) begin
            press(10'(1) << k, 5, 6, 1'b0, np, lat, d, pg);
            if (model.size() < 4) model.push_back(k);
            vecs++; if (np !== 1 || d !== 4'(k)) begin errs++; $display("FAIL fill_key%0d got pulses=%0d D=%h exp 1 %h", k, np, d, 4'(k)); end
            vecs++; if (bus.entry !== model_entry() || bus.full !== (model.size() == 4)) begin errs++; $display("FAIL fill_entry%0d got %h full=%b exp %h", k, bus.entry, bus.full, model_entry()); end
        end
        vecs++; if (bus.entry !== 16'h1234 || bus.full !== 1'b1) begin errs++; $display("FAIL fill_overflow got %h full=%b exp 1234 1", bus.entry, bus.full); end
    endtask

    task automatic test_cancel_collision();
        int np, lat;
        logic [3:0] d;
        logic pg;
        do_cancel();
        press(10'h008, 5, 6, 1'b0, np, lat, d, pg);
        model.push_back(3);
        vecs++; if (bus.entry !== model_entry()) begin errs++; $display("FAIL cancel_pre_entry got %h exp %h", bus.entry, model_entry()); end
        press(10'h080, 5, 6, 1'b1, np, lat, d, pg);
        model.delete();
        vecs++; if (np !== 1 || d !== 4'd7) begin errs++; $display("FAIL cancel_pulse got pulses=%0d D=%h exp 1 7", np, d); end
        vecs++; if (bus.entry !== 16'h0 || bus.full !== 1'b0) begin errs++; $display("FAIL cancel_clear got %h full=%b exp 0 0", bus.entry, bus.full); end
    endtask

    task automatic test_random();
        int np, lat, dg, hold, gap;
        logic [3:0] d;
        logic pg;
        logic [9:0] one, mask;
        one = 10'd1;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_cancel();
                vecs++; if (bus.entry !== 16'h0 || bus.full !== 1'b0) begin errs++; $display("FAIL rnd_cancel%0d got %h full=%b exp 0 0", n, bus.entry, bus.full); end
            end
            dg = $urandom_range(0, 9);
            mask = (one << dg) | (10'($urandom) & ((one << dg) - one));
            hold = $urandom_range(4, 8);
            gap = $urandom_range(5, 9);
            press(mask, hold, gap, 1'b0, np, lat, d, pg);
            if (model.size() < 4) model.push_back(dg);
            vecs++; if (np !== 1 || lat !== 5 || d !== 4'(dg) || pg !== 1'b1) begin errs++; $display("FAIL rnd_key%0d mask=%h got pulses=%0d lat=%0d D=%h pgt=%b exp 1 5 %h 1", n, mask, np, lat, d, pg, 4'(dg)); end
            vecs++; if (bus.entry !== model_entry() || bus.full !== (model.size() == 4)) begin errs++; $display("FAIL rnd_entry%0d got %h full=%b exp %h %b", n, bus.entry, bus.full, model_entry(), model.size() == 4); end
        end
    endtask

    task automatic test_run_ticks();
        int ticks[$];
        int lows, first;
        lows = 0;
        first = -1;
        bus.keypad = 10'h002;
        bus.enablen = 1'b0;
        for (int i = 0; i < 350; i++) begin
            tick();
            if (bus.pgt_1Hz) ticks.push_back(i);
            if (!bus.loadn) lows++;
        end
        vecs++; if (lows !== 0) begin errs++; $display("FAIL run_locked got %0d pulses exp 0", lows); end
        vecs++; if (ticks.size() !== 3) begin errs++; $display("FAIL run_tick_count got %0d exp 3", ticks.size()); end
        for (int j = 0; j < 3 && j < ticks.size(); j++) begin
            vecs++; if (ticks[j] !== 100 * (j + 1)) begin errs++; $display("FAIL run_tick%0d got %0d exp %0d", j, ticks[j], 100 * (j + 1)); end
        end
        bus.keypad = '0;
        for (int i = 0; i < 5; i++) tick();
        bus.enablen = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.enablen = 1'b0;
        for (int i = 0; i < 150 && first < 0; i++) begin
            tick();
            if (bus.pgt_1Hz) first = i;
        end
        vecs++; if (first !== 100) begin errs++; $display("FAIL run_restart got %0d exp 100", first); end
        bus.enablen = 1'b1;
    endtask

    initial begin
        bus.keypad = '0;
        bus.enablen = 1'b1;
        bus.cancel = 1'b0;
        test_reset();
        test_reset_mid_settle();
        test_priority();
        test_bounce();
        test_fill();
        test_cancel_collision();
        test_random();
        test_run_ticks();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
